op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Command scheduler that drives the matrix-engine controller's `operation` and `in_data` inputs.
- Accepts 32-bit operation words through a valid/ready command port and queues them in a small FIFO.
- Issues each command to the controller for exactly as long as that controller needs:
  - opcode 1 (multiply): held for the shift phase plus the write-back drain.
  - opcode 2 (serial page load): driven once per accepted data-stream word.
- Guarantees an idle gap between commands, so every opcode-1 rising edge is seen and restarts the multiply counters.

Parameters:
- FIFO_DEPTH, 4: command queue entries (power of 2, ≥2).
- MUL_CYCLES, 64: cycles of opcode 1 while memory shifts operands. Matches a 16-cell × 2-line W page × 2-line X page.
- DRAIN_CYCLES, 16: extra cycles opcode 1 is held so the multiplier's bulk Y write-back completes (X write enable depends on opcode 1).
- LOAD_WORDS, 128: data words per opcode-2 command.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  global enable; low freezes all state
- cmd_valid  in  1  command word valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_data  in  32  operation word; [3:0] opcode, [7:4] A, [11:8] B, [15:12] C, [19:16] config
- dat_valid  in  1  load data valid
- dat_ready  out  1  sequencer accepts load data
- dat_data  in  32  load data word
- operation  out  32  operation word to controller (registered)
- in_data  out  32  data word to controller (registered)
- busy  out  1  state≠IDLE or FIFO non-empty
- done  out  1  one-cycle pulse when a command retires
- err  out  1  one-cycle pulse when an illegal opcode is dropped
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued commands

Behaviour:
- Reset (synchronous, overrides enable):
  - state IDLE, FIFO emptied, all counters 0.
  - operation=0, in_data=0, done=0, err=0, dat_ready=0, cmd_ready=1.
  - Reset mid-command aborts it with no done pulse.
- enable=0:
  - No push, pop, counter or state change.
  - Registered outputs hold; done and err forced 0.
  - cmd_ready=0 and dat_ready=0.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready = enable && count<FIFO_DEPTH. No fall-through when full, even if a pop happens the same cycle.
  - A push and pop in the same cycle leave count unchanged.
- States: IDLE, MUL, DRAIN, LOAD, GAP.
- IDLE:
  - operation=0.
  - If FIFO non-empty, pop the head and decode opcode:
    - 1 → MUL, operation←word, counter←0.
    - 2 → LOAD, counter←0.
    - 0 → dropped silently, stay IDLE.
    - 3–15 → err=1 next cycle, stay IDLE.
  - Latency: command pushed at cycle t gives operation valid at t+2 when the FIFO was empty.
- MUL:
  - operation=word for MUL_CYCLES cycles.
  - When counter==MUL_CYCLES-1 → DRAIN, counter←0.
- DRAIN:
  - operation=word for DRAIN_CYCLES cycles.
  - If DRAIN_CYCLES=0, go MUL→GAP directly.
  - Opcode 1 is therefore high for exactly MUL_CYCLES+DRAIN_CYCLES contiguous cycles.
- LOAD:
  - dat_ready=enable.
  - On each dat_valid&&dat_ready, next cycle: operation=word, in_data=dat_data, counter++.
  - On a cycle with no transfer, next-cycle operation=0 so the controller performs no write; in_data holds.
  - After the LOAD_WORDS-th transfer → GAP; dat_ready drops in the same cycle the state leaves LOAD.
- GAP:
  - Exactly one cycle, operation=0, done=1 → IDLE.
  - Back-to-back commands are therefore separated by ≥2 idle cycles (GAP + IDLE decode).
- Counters: width $clog2(max(MUL_CYCLES, DRAIN_CYCLES, LOAD_WORDS))+1, compared for equality; no wrap is reachable.
- busy is combinational from state and count.

Decomposition:
- Package seq_pkg holds:
  - opcode constants OP_IDLE=0, OP_MUL=1, OP_LOAD=2;
  - state encoding;
  - operation field offsets.
- One natural sub-module: cmd_fifo, a parameterised synchronous FIFO with push/pop/count/full/empty. FSM and counters stay in op_sequencer.

Test Plan:
1. Reset → operation=0, done=0, err=0, busy=0, cmd_ready=1, fifo_count=0. Assert reset mid-MUL → operation=0 next cycle, no done pulse.
2. MUL_CYCLES=4, DRAIN_CYCLES=2; push 0x00002101 at t0 → operation=0x00002101 for t0+2..t0+7, operation=0 with done=1 at t0+8, busy=0 at t0+9.
3. LOAD_WORDS=3; push 0x00000F82, data 0xA, 0xB, 0xC with a 2-cycle dat_valid gap after 0xA → operation=0x00000F82 only in the three cycles after each transfer, 0 during the gap; in_data follows A, B, C; done after the third word.
4. FIFO_DEPTH=4; hold sequencer in MUL and push 6 commands → cmd_ready=0 after 4 queued (when 1 command is in service); the queued commands issue in order, each separated by GAP+IDLE.
5. Push 0x00000005, then 0x00002101 → err pulse, no operation change for the bad word; the multiply then issues normally.
6. Drop enable for 3 cycles mid-MUL → operation and counter frozen; opcode-1 total duration extended by exactly 3 cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared opcodes, sequencer states and operation-word field offsets
package seq_pkg;
  localparam logic [3:0] OP_IDLE = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_LOAD = 4'd2;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 0;
  localparam int A_LSB = 4;
  localparam int B_LSB = 8;
  localparam int C_LSB = 12;
  localparam int CFG_LSB = 16;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DRAIN, S_LOAD, S_GAP} state_t;
  function automatic int max3(int a, int b, int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with push/pop/count/full/empty; caller guards push on full and pop on empty
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage array, no reset needed since count gates every read
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: queues operation words and drives the matrix controller for exactly the cycles each opcode needs
module op_sequencer
  import seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MUL_CYCLES = 64,
  parameter int DRAIN_CYCLES = 16,
  parameter int LOAD_WORDS = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [31:0]                     cmd_data,
  input  logic                            dat_valid,
  output logic                            dat_ready,
  input  logic [31:0]                     dat_data,
  output logic [31:0]                     operation,
  output logic [31:0]                     in_data,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int CW = $clog2(max3(MUL_CYCLES, DRAIN_CYCLES, LOAD_WORDS)) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES == 0 ? 0 : DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_WORDS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0] word, word_n, op_n, din_n, head;
  logic err_q, err_n, push, pop, full, empty, xfer;
  logic [FIELD_W-1:0] opc;
  assign opc = head[OPC_LSB +: FIELD_W];
  assign cmd_ready = enable && !full;
  assign push = cmd_valid && cmd_ready;
  assign pop = enable && state == S_IDLE && !empty;
  assign dat_ready = enable && state == S_LOAD;
  assign xfer = dat_valid && dat_ready;
  assign busy = state != S_IDLE || !empty;
  assign done = enable && state == S_GAP;
  assign err = enable && err_q;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(cmd_data),
    .dout(head),
    .count(fifo_count),
    .full(full),
    .empty(empty)
  );
  // next state, counter and registered outputs; enable low leaves every default in place
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    word_n = word;
    op_n = operation;
    din_n = in_data;
    err_n = enable ? 1'b0 : err_q;
    if (enable)
      case (state)
        S_IDLE: begin
          op_n = '0;
          if (!empty) begin
            cnt_n = '0;
            word_n = head;
            if (opc == OP_MUL) begin
              state_n = S_MUL;
              op_n = head;
            end else if (opc == OP_LOAD) state_n = S_LOAD;
            else err_n = opc != OP_IDLE;
          end
        end
        S_MUL: begin
          cnt_n = cnt == MUL_LAST ? '0 : cnt + 1'b1;
          if (cnt == MUL_LAST) begin
            state_n = DRAIN_CYCLES == 0 ? S_GAP : S_DRAIN;
            op_n = DRAIN_CYCLES == 0 ? '0 : word;
          end
        end
        S_DRAIN: begin
          cnt_n = cnt == DRAIN_LAST ? '0 : cnt + 1'b1;
          state_n = cnt == DRAIN_LAST ? S_GAP : S_DRAIN;
          op_n = cnt == DRAIN_LAST ? '0 : word;
        end
        S_LOAD: begin
          op_n = xfer ? word : '0;
          din_n = xfer ? dat_data : in_data;
          cnt_n = xfer ? (cnt == LOAD_LAST ? '0 : cnt + 1'b1) : cnt;
          state_n = xfer && cnt == LOAD_LAST ? S_GAP : S_LOAD;
        end
        S_GAP: begin
          op_n = '0;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
  end
  // state and output registers; reset aborts any command in flight
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      word <= '0;
      operation <= '0;
      in_data <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      word <= word_n;
      operation <= op_n;
      in_data <= din_n;
      err_q <= err_n;
    end
endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer: randomized scoreboard bench for op_sequencer with directed timing checks
module tb_op_sequencer;
  localparam int FD = 4, MC = 4, DC = 2, LW = 3;
  typedef struct {
    logic [31:0] op;
    logic [31:0] din;
    logic chk_din;
    logic done;
    logic err;
  } ev_t;
  logic clk = 1'b0, reset = 1'b1, enable, cmd_valid = 1'b0, cmd_ready, dat_valid, dat_ready;
  logic [31:0] cmd_data = '0, dat_data, operation, in_data;
  logic busy, done, err;
  logic [$clog2(FD):0] fifo_count;
  logic mon_on = 1'b0, rand_en = 1'b0, hold_dis = 1'b0, dat_on = 1'b0;
  int checks = 0, errors = 0, cyc = 0, dptr = 0, dload = 0, t_acc = 0;
  logic [31:0] dq [256];
  ev_t expq[$];

  op_sequencer #(.FIFO_DEPTH(FD), .MUL_CYCLES(MC), .DRAIN_CYCLES(DC), .LOAD_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_data(dat_data),
    .operation(operation), .in_data(in_data), .busy(busy), .done(done), .err(err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // reference model: the observable event sequence each accepted command must produce
  task automatic model_push(input logic [31:0] w);
    case (w[3:0])
      4'd0: ;
      4'd1: begin
        repeat (MC + DC) expq.push_back('{w, 32'h0, 1'b0, 1'b0, 1'b0});
        expq.push_back('{32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      end
      4'd2: begin
        for (int i = 0; i < LW; i++)
          expq.push_back('{w, dq[(dload + i) % 256], 1'b1, i == LW - 1, 1'b0});
        dload += LW;
      end
      default: expq.push_back('{32'h0, 32'h0, 1'b0, 1'b0, 1'b1});
    endcase
  endtask

  task automatic send(input logic [31:0] w);
    int b = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data = w;
    #2;
    while (!cmd_ready && b < 300) begin
      @(negedge clk);
      #2;
      b++;
    end
    if (!cmd_ready) chk("send_timeout", {31'h0, cmd_ready}, 32'h1);
    else begin
      t_acc = cyc;
      model_push(w);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_op();
    int b = 0;
    do begin
      @(negedge clk);
      #2;
      b++;
    end while (operation == 0 && b < 100);
    if (operation == 0) chk("wait_op_timeout", operation, 32'h1);
  endtask

  task automatic wait_idle();
    int b = 0;
    do begin
      @(negedge clk);
      #2;
      b++;
    end while ((busy || expq.size() != 0) && b < 3000);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_queue", expq.size(), 32'h0);
  endtask

  // input driver: enable and the load data stream, advancing the data pointer on each transfer
  initial forever begin
    @(negedge clk);
    enable = !hold_dis && !(rand_en && $urandom_range(0, 9) == 0);
    dat_valid = dat_on && $urandom_range(0, 3) != 0;
    dat_data = dq[dptr % 256];
    #1 if (dat_valid && dat_ready) dptr++;
  end

  // scoreboard monitor: every cycle showing activity must match the next expected event
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_on && !reset && enable && (operation != 0 || done || err)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: op=%h done=%b err=%b with nothing expected", operation, done, err);
      end else begin
        ev_t e;
        e = expq.pop_front();
        checks++;
        if (operation !== e.op || done !== e.done || err !== e.err || (e.chk_din && in_data !== e.din)) begin
          errors++;
          $display("FAIL event: got op=%h din=%h done=%b err=%b expected op=%h din=%h done=%b err=%b",
                   operation, in_data, done, err, e.op, e.din, e.done, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, j;
    logic [31:0] w;
    logic [3:0] opc_tab [8];
    opc_tab = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd7, 4'd15};
    for (int i = 0; i < 256; i++) dq[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_operation", operation, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 1);
    chk("rst_fifo_count", {29'h0, fifo_count}, 0);
    chk("rst_dat_ready", {31'h0, dat_ready}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    send(32'h00002101);
    wait_op();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("midrst_operation", operation, 0);
    chk("midrst_busy", {31'h0, busy}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #2;
      chk("midrst_no_done", {31'h0, done}, 0);
      chk("midrst_no_op", operation, 0);
    end
    expq.delete();
    mon_on = 1'b1;
    send(32'h00002101);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #2;
      chk("lat_operation", operation, (cyc - t_acc >= 2 && cyc - t_acc <= 2 + MC + DC - 1) ? 32'h00002101 : 32'h0);
      if (cyc - t_acc == 2 + MC + DC) chk("lat_done", {31'h0, done}, 1);
      if (cyc - t_acc == 3 + MC + DC) chk("lat_busy", {31'h0, busy}, 0);
    end
    wait_idle();
    dat_on = 1'b1;
    send(32'h00000F82);
    wait_idle();
    chk("load_last_in_data", in_data, dq[(dload - 1) % 256]);
    send(32'h00002101);
    wait_op();
    for (int i = 0; i < 4; i++) send(32'h00003101 + (i << 16));
    @(negedge clk);
    #2;
    chk("full_count", {29'h0, fifo_count}, FD);
    chk("full_cmd_ready", {31'h0, cmd_ready}, 0);
    chk("full_busy", {31'h0, busy}, 1);
    send(32'h00009101);
    wait_idle();
    send(32'h00000005);
    send(32'h00002101);
    wait_idle();
    send(32'h00004101);
    wait_op();
    hold_dis = 1'b1;
    n = 1;
    j = 0;
    do begin
      @(negedge clk);
      #2;
      j++;
      if (j == 3) hold_dis = 1'b0;
      if (operation == 32'h00004101) n++;
    end while (operation == 32'h00004101 && j < 50);
    chk("stall_duration", n, MC + DC + 3);
    wait_idle();
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      w[3:0] = opc_tab[$urandom_range(0, 7)];
      send(w);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    wait_idle();
    rand_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
